// File: rtl/range_cam_match_iter.sv
// range_cam_match_iter: serialises a CAM match bitmap into matching addresses, lowest first, with valid/ready backpressure
module range_cam_match_iter #(
  parameter int NUMADDR = 1024,
  parameter int BITADDR = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bmp_vld,
  input  logic [NUMADDR-1:0] bmp,
  output logic               bmp_rdy,
  input  logic               flush,
  output logic               out_vld,
  output logic [BITADDR-1:0] out_adr,
  output logic               out_last,
  output logic               out_none,
  input  logic               out_rdy,
  output logic               busy,
  output logic [BITADDR:0]   match_cnt
);
  typedef enum logic [1:0] {IDLE, SCAN, NONE} state_t;
  state_t state, state_n;
  logic [NUMADDR-1:0] pend, pend_n, pend_rest;
  logic [BITADDR:0] cnt_n;
  logic [BITADDR-1:0] idx;
  logic take, fire;
  always_comb begin
    idx = '0;
    for (int i = NUMADDR-1; i >= 0; i--)
      if (pend[i]) idx = i[BITADDR-1:0];
  end
  assign pend_rest = pend & (pend - NUMADDR'(1));
  assign bmp_rdy   = (state == IDLE) && !rst;
  assign busy      = state != IDLE;
  assign out_vld   = state != IDLE;
  assign out_none  = state == NONE;
  assign out_adr   = state == SCAN ? idx : '0;
  assign out_last  = state == NONE || (state == SCAN && pend_rest == '0);
  assign take      = bmp_vld && bmp_rdy;
  assign fire      = state == SCAN && out_rdy;
  always_comb begin
    state_n = take ? (|bmp ? SCAN : NONE) : (out_vld && out_rdy && out_last) ? IDLE : state;
    pend_n  = take ? bmp : fire ? pend_rest : pend;
    cnt_n   = take ? '0 : fire ? match_cnt + (BITADDR+1)'(1) : match_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      match_cnt <= '0;
    end else if (flush) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      match_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_range_cam_match_iter.sv
// tb_range_cam_match_iter: directed self-checking bench for range_cam_match_iter
module tb_range_cam_match_iter;
  logic clk = 0, rst = 1, bmp_vld = 0, flush = 0, out_rdy = 0;
  logic [1023:0] bmp = '0;
  logic bmp_rdy, out_vld, out_last, out_none, busy;
  logic [9:0] out_adr;
  logic [10:0] match_cnt;
  int checks = 0, errors = 0;
  range_cam_match_iter dut (
    .clk(clk), .rst(rst), .bmp_vld(bmp_vld), .bmp(bmp), .bmp_rdy(bmp_rdy), .flush(flush),
    .out_vld(out_vld), .out_adr(out_adr), .out_last(out_last), .out_none(out_none),
    .out_rdy(out_rdy), .busy(busy), .match_cnt(match_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic beat(input string tag, input logic [31:0] adr, input logic last, input logic [31:0] cnt);
    chk({tag, " vld"}, out_vld, 1);
    chk({tag, " adr"}, out_adr, adr);
    chk({tag, " last"}, out_last, last);
    chk({tag, " none"}, out_none, 0);
    chk({tag, " cnt"}, match_cnt, cnt);
    chk({tag, " rdy"}, bmp_rdy, 0);
  endtask
  task automatic idle(input string tag, input logic [31:0] cnt);
    chk({tag, " idle vld"}, out_vld, 0);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle rdy"}, bmp_rdy, 1);
    chk({tag, " idle cnt"}, match_cnt, cnt);
  endtask
  initial begin
    tick();
    chk("rst vld", out_vld, 0);
    chk("rst rdy", bmp_rdy, 0);
    chk("rst busy", busy, 0);
    chk("rst cnt", match_cnt, 0);
    chk("rst adr", out_adr, 0);
    chk("rst last", out_last, 0);
    chk("rst none", out_none, 0);
    rst = 0;
    #1;
    idle("post rst", 0);
    out_rdy = 1;
    bmp = '0; bmp[3] = 1; bmp[17] = 1; bmp[1023] = 1; bmp_vld = 1;
    tick(); bmp_vld = 0;
    beat("t1 b0", 3, 0, 0);
    tick(); beat("t1 b1", 17, 0, 1);
    tick(); beat("t1 b2", 1023, 1, 2);
    tick(); idle("t1", 3);
    bmp = '0; bmp_vld = 1;
    tick(); bmp_vld = 0;
    chk("t2 vld", out_vld, 1);
    chk("t2 none", out_none, 1);
    chk("t2 last", out_last, 1);
    chk("t2 adr", out_adr, 0);
    chk("t2 cnt", match_cnt, 0);
    tick(); idle("t2", 0);
    out_rdy = 0;
    bmp = '0; bmp[5] = 1; bmp[6] = 1; bmp_vld = 1;
    tick(); bmp_vld = 0;
    for (int i = 0; i < 5; i++) begin
      beat("t3 hold", 5, 0, 0);
      chk("t3 busy", busy, 1);
      if (i < 4) tick();
    end
    out_rdy = 1;
    tick(); beat("t3 b1", 6, 1, 1);
    tick(); idle("t3", 2);
    bmp = '1; bmp_vld = 1;
    tick();
    bmp = '0; bmp[7] = 1;
    for (int k = 0; k < 1024; k++) begin
      chk("t4 adr", out_adr, k);
      chk("t4 last", out_last, k == 1023);
      chk("t4 rdy", bmp_rdy, 0);
      tick();
    end
    idle("t4", 1024);
    tick(); bmp_vld = 0;
    beat("t4 next", 7, 1, 0);
    tick(); idle("t4 next", 1);
    bmp = '0; bmp[1] = 1; bmp[2] = 1; bmp[3] = 1; bmp_vld = 1;
    tick(); bmp_vld = 0;
    beat("t5 b0", 1, 0, 0);
    tick(); beat("t5 b1", 2, 0, 1);
    flush = 1;
    tick(); flush = 0;
    idle("t5 flush", 1);
    bmp = '0; bmp[9] = 1; bmp_vld = 1;
    tick(); bmp_vld = 0;
    beat("t5 new", 9, 1, 0);
    tick(); idle("t5", 1);
    bmp = '0; bmp[0] = 1; bmp[100] = 1; bmp_vld = 1;
    tick(); bmp_vld = 0;
    beat("t6 b0", 0, 0, 0);
    rst = 1;
    tick();
    chk("t6 vld", out_vld, 0);
    chk("t6 rdy", bmp_rdy, 0);
    chk("t6 cnt", match_cnt, 0);
    chk("t6 busy", busy, 0);
    tick();
    chk("t6 vld2", out_vld, 0);
    rst = 0;
    #1;
    idle("t6", 0);
    tick();
    chk("t6 after vld", out_vld, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
